n64_cursor: RTL and testbench

Consumes the 30-bit status reports from the N64 controller interface and turns them into game-level commands for the battleship board. It maintains a clamped cursor position driven by D-pad (and optionally joystick) with auto-repeat, and produces one-cycle press pulses for A (fire), B (rotate) and Start. It sits directly downstream of the controller poller and upstream of the game control FSM.

---
 rtl/n64_cursor.sv | 124 ++++++++++++
 tb/tb_n64_cursor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/n64_cursor.sv
// n64_cursor: turns N64 controller reports into a clamped board cursor and A/B/Start press pulses.
// Define N64_CURSOR_JOYSTICK_EN to let the analog stick steer the cursor alongside the D-pad.
module n64_cursor #(
    parameter int BOARD_W      = 10,
    parameter int BOARD_H      = 10,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 3,
    parameter int JOY_THRESH   = 40
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [29:0] i_din,
    input  logic        i_in_valid,
    output logic [3:0]  o_cursor_x,
    output logic [3:0]  o_cursor_y,
    output logic        o_moved,
    output logic        o_fire,
    output logic        o_rotate,
    output logic        o_start_press
);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DELAY_TC = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_TC  = CW'(REPEAT_RATE - 1);
    localparam logic [3:0] X_MAX = 4'(BOARD_W - 1);
    localparam logic [3:0] Y_MAX = 4'(BOARD_H - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_dir;
    logic [2:0]    r_btn_prev;
    logic [3:0]    r_x, r_y;
    logic          r_moved;
    logic [2:0]    r_pulse;
    logic [3:0]    w_raw, w_joy, w_dir;
    logic [2:0]    w_btn;
    logic          w_move;
    logic [3:0]    w_x_nxt, w_y_nxt;
    logic          w_unused;

`ifdef N64_CURSOR_JOYSTICK_EN
    localparam logic signed [8:0] THRESH = 9'(JOY_THRESH);
    logic signed [8:0] w_jx, w_jy;
    assign w_jx     = {i_din[15], i_din[15:8]};
    assign w_jy     = {i_din[7], i_din[7:0]};
    assign w_joy    = {w_jy > THRESH, w_jy < -THRESH, w_jx < -THRESH, w_jx > THRESH};
    assign w_unused = ^{i_din[27], i_din[21:16]};
`else
    assign w_joy    = 4'b0000;
    assign w_unused = ^{i_din[27], i_din[21:0]};
`endif

    // direction bits are {U,D,L,R}; opposing pairs cancel each other
    assign w_raw = i_din[25:22] | w_joy;
    assign w_dir = {w_raw[3] & ~w_raw[2], w_raw[2] & ~w_raw[3], w_raw[1] & ~w_raw[0], w_raw[0] & ~w_raw[1]};
    assign w_btn = {i_din[29], i_din[28], i_din[26]};

    // repeat FSM: decide whether this report moves the cursor and advance the hold counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_move      = 1'b0;
        if (i_in_valid) begin
            if (w_dir == 4'd0) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else if (r_state == IDLE || w_dir != r_dir) begin
                w_move      = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = HOLD;
            end else if (r_cnt == ((r_state == HOLD) ? DELAY_TC : RATE_TC)) begin
                w_move      = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = REPEAT;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // clamped step of each axis; no wrap at the board edges
    always_comb begin
        w_x_nxt = !w_move ? r_x :
                  (w_dir[0] && r_x != X_MAX) ? r_x + 4'd1 :
                  (w_dir[1] && r_x != 4'd0) ? r_x - 4'd1 : r_x;
        w_y_nxt = !w_move ? r_y :
                  (w_dir[2] && r_y != Y_MAX) ? r_y + 4'd1 :
                  (w_dir[3] && r_y != 4'd0) ? r_y - 4'd1 : r_y;
    end

    // state, cursor and pulse registers; buttons start "held" so a press through reset is ignored
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dir      <= 4'd0;
            r_btn_prev <= 3'b111;
            r_x        <= 4'd0;
            r_y        <= 4'd0;
            r_moved    <= 1'b0;
            r_pulse    <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_moved <= (w_x_nxt != r_x) || (w_y_nxt != r_y);
            r_pulse <= i_in_valid ? (w_btn & ~r_btn_prev) : 3'b000;
            if (i_in_valid) begin
                r_dir      <= w_dir;
                r_btn_prev <= w_btn;
            end
        end
    end

    assign o_cursor_x    = r_x;
    assign o_cursor_y    = r_y;
    assign o_moved       = r_moved;
    assign o_fire        = r_pulse[2];
    assign o_rotate      = r_pulse[1];
    assign o_start_press = r_pulse[0];
endmodule

// File: tb/tb_n64_cursor.sv
// tb_n64_cursor: table-driven directed check of cursor moves, auto-repeat, clamping, buttons and reset.
module tb_n64_cursor;
`ifdef N64_CURSOR_JOYSTICK_EN
    localparam bit JOY = 1'b1;
`else
    localparam bit JOY = 1'b0;
`endif
    localparam logic [29:0] BA = 30'h1 << 29;
    localparam logic [29:0] BB = 30'h1 << 28;
    localparam logic [29:0] BS = 30'h1 << 26;
    localparam logic [29:0] DU = 30'h1 << 25;
    localparam logic [29:0] DD = 30'h1 << 24;
    localparam logic [29:0] DL = 30'h1 << 23;
    localparam logic [29:0] DR = 30'h1 << 22;

    typedef struct {
        string       nm;
        logic [29:0] din;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [3:0]  p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] din = 30'd0;
    logic        in_valid = 1'b0;
    logic [3:0]  cx, cy;
    logic        moved, fire, rotate, start_press;
    int          errors = 0;
    int          checks = 0;
    vec_t        tv[$];

    n64_cursor dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_in_valid(in_valid),
        .o_cursor_x(cx), .o_cursor_y(cy), .o_moved(moved), .o_fire(fire),
        .o_rotate(rotate), .o_start_press(start_press)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic [29:0] d, input int x, input int y, input logic [3:0] p);
        vec_t e;
        e.nm = nm;
        e.din = d;
        e.x = 4'(x);
        e.y = 4'(y);
        e.p = p;
        tv.push_back(e);
    endtask

    task automatic step(input logic [29:0] d, input logic v);
        @(negedge clk);
        din = d;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] ex, input logic [3:0] ey, input logic [3:0] ep);
        checks++;
        if ({cx, cy, moved, fire, rotate, start_press} !== {ex, ey, ep}) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d mfrs=%b, expected x=%0d y=%0d mfrs=%b",
                     nm, cx, cy, {moved, fire, rotate, start_press}, ex, ey, ep);
        end
    endtask

    initial begin
        add("a_held_reset", BA, 0, 0, 4'b0000);
        add("a_release", 30'd0, 0, 0, 4'b0000);
        add("a_press", BA, 0, 0, 4'b0100);
        add("a_hold", BA, 0, 0, 4'b0000);
        add("b_start", BB | BS, 0, 0, 4'b0011);
        add("idle", 30'd0, 0, 0, 4'b0000);
        for (int k = 1; k <= 12; k++)
            add("rpt_r", DR, (k < 9) ? 1 : (k < 12) ? 2 : 3, 0, {(k == 1 || k == 9 || k == 12), 3'b000});
        add("rel", 30'd0, 3, 0, 4'b0000);
        add("ud_r", DU | DD | DR, 4, 0, 4'b1000);
        add("rel", 30'd0, 4, 0, 4'b0000);
        add("all4", DU | DD | DL | DR, 4, 0, 4'b0000);
        add("rel", 30'd0, 4, 0, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            add("down", DD, 4, k, 4'b1000);
            add("rel", 30'd0, 4, k, 4'b0000);
        end
        for (int k = 5; k <= 9; k++) begin
            add("right", DR, k, 5, 4'b1000);
            add("rel", 30'd0, k, 5, 4'b0000);
        end
        for (int k = 1; k <= 20; k++)
            add("edge_r", DR, 9, 5, 4'b0000);
        add("rel", 30'd0, 9, 5, 4'b0000);
        add("left", DL, 8, 5, 4'b1000);
        add("rel", 30'd0, 8, 5, 4'b0000);
        add("joy_x41", 30'h2900, JOY ? 9 : 8, 5, JOY ? 4'b1000 : 4'b0000);
        add("rel", 30'd0, JOY ? 9 : 8, 5, 4'b0000);
        add("joy_x40", 30'h2800, JOY ? 9 : 8, 5, 4'b0000);
        add("rel", 30'd0, JOY ? 9 : 8, 5, 4'b0000);
        add("joy_xm41", 30'hD700, 8, 5, JOY ? 4'b1000 : 4'b0000);
        add("rel", 30'd0, 8, 5, 4'b0000);
        add("joy_ym41", 30'h00D7, 8, JOY ? 6 : 5, JOY ? 4'b1000 : 4'b0000);
        add("rel", 30'd0, 8, JOY ? 6 : 5, 4'b0000);
        add("joy_yp41", 30'h0029, 8, 5, JOY ? 4'b1000 : 4'b0000);
        add("rel", 30'd0, 8, 5, 4'b0000);
        add("joy_cancel", DD | 30'h0029, 8, JOY ? 5 : 6, JOY ? 4'b0000 : 4'b1000);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 4'd0, 4'd0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].din, 1'b1);
            chk(tv[i].nm, tv[i].x, tv[i].y, tv[i].p);
            step(30'd0, 1'b0);
            chk({tv[i].nm, "_gap"}, tv[i].x, tv[i].y, 4'b0000);
        end

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_again", 4'd0, 4'd0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k <= 10; k++) begin
            step(DD, 1'b1);
            chk("b2b_down", 4'd0, (k < 9) ? 4'd1 : 4'd2, {(k == 1 || k == 9), 3'b000});
        end
        @(negedge clk);
        din = DD | BA;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4'd0, 4'd0, 4'b0000);
        @(posedge clk);
        #1;
        chk("reset_held", 4'd0, 4'd0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        step(DD | BA, 1'b1);
        chk("post_rst_first", 4'd0, 4'd1, 4'b1000);
        step(DD | BA, 1'b1);
        chk("post_rst_hold", 4'd0, 4'd1, 4'b0000);
        step(DD, 1'b1);
        chk("post_rst_a_rel", 4'd0, 4'd1, 4'b0000);
        step(DD | BA, 1'b1);
        chk("post_rst_a_press", 4'd0, 4'd1, 4'b0100);
        step(30'd0, 1'b0);
        chk("post_rst_gap", 4'd0, 4'd1, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
